// File: rtl/bitop_accum_if.sv
// bitop_accum_if: valid/ready word input and frame result output for bitop_accum.
// The out_zero signal exists only when BITOP_ACCUM_ZERO_EN is defined.
interface bitop_accum_if #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             in_last;
    logic [1:0]       in_mode;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [CNT_W-1:0] out_count;
`ifdef BITOP_ACCUM_ZERO_EN
    logic             out_zero;
    modport master (output in_valid, in_data, in_last, in_mode, out_ready,
                    input in_ready, out_valid, out_data, out_count, out_zero);
    modport slave  (input in_valid, in_data, in_last, in_mode, out_ready,
                    output in_ready, out_valid, out_data, out_count, out_zero);
`else
    modport master (output in_valid, in_data, in_last, in_mode, out_ready,
                    input in_ready, out_valid, out_data, out_count);
    modport slave  (input in_valid, in_data, in_last, in_mode, out_ready,
                    output in_ready, out_valid, out_data, out_count);
`endif
endinterface

// File: rtl/bitop_accum.sv
// bitop_accum: framed cumulative OR/AND/XOR/NOR over WIDTH-bit words, one result per frame.
// Optional out_zero flag is enabled with BITOP_ACCUM_ZERO_EN.
module bitop_accum #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 4
) (
    input logic        clk,
    input logic        reset,
    bitop_accum_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d, acc_nxt, out_data_q, out_data_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_nxt, out_count_q, out_count_d;
    logic [1:0]       mode_q, mode_d, mode_eff;
    logic             first, xfer_in;
`ifdef BITOP_ACCUM_ZERO_EN
    logic             zero_q, zero_d;
`endif

    // NOR accumulates as OR; the inversion is applied only when the result is latched.
    always_comb begin
        first       = state_q == IDLE;
        mode_eff    = first ? bus.in_mode : mode_q;
        acc_nxt     = first ? bus.in_data :
                      mode_q == 2'b01 ? acc_q & bus.in_data :
                      mode_q == 2'b10 ? acc_q ^ bus.in_data : acc_q | bus.in_data;
        cnt_nxt     = first ? CNT_W'(1) : &cnt_q ? cnt_q : cnt_q + 1'b1;
        xfer_in     = bus.in_valid && state_q != HOLD;
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        mode_d      = mode_q;
        out_data_d  = out_data_q;
        out_count_d = out_count_q;
        if (xfer_in) begin
            acc_d   = acc_nxt;
            cnt_d   = cnt_nxt;
            mode_d  = mode_eff;
            state_d = bus.in_last ? HOLD : ACCUM;
            if (bus.in_last) begin
                out_data_d  = &mode_eff ? ~acc_nxt : acc_nxt;
                out_count_d = cnt_nxt;
            end
        end
        if (state_q == HOLD && bus.out_ready) state_d = IDLE;
`ifdef BITOP_ACCUM_ZERO_EN
        zero_d = (xfer_in && bus.in_last) ? out_data_d == '0 : zero_q;
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            mode_q      <= 2'b00;
            out_data_q  <= '0;
            out_count_q <= '0;
`ifdef BITOP_ACCUM_ZERO_EN
            zero_q      <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            mode_q      <= mode_d;
            out_data_q  <= out_data_d;
            out_count_q <= out_count_d;
`ifdef BITOP_ACCUM_ZERO_EN
            zero_q      <= zero_d;
`endif
        end
    end

    assign bus.in_ready  = state_q != HOLD;
    assign bus.out_valid = state_q == HOLD;
    assign bus.out_data  = out_data_q;
    assign bus.out_count = out_count_q;
`ifdef BITOP_ACCUM_ZERO_EN
    assign bus.out_zero  = zero_q;
`endif
endmodule

// File: tb/tb_bitop_accum.sv
// tb_bitop_accum: directed and randomized frames checked against a fold-over-queue model.
// Checks out_zero only when BITOP_ACCUM_ZERO_EN is defined.
module tb_bitop_accum;
    localparam int W  = 16;
    localparam int CW = 4;
    localparam int SAT = (1 << CW) - 1;

    logic clk = 0;
    logic reset = 1;
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    logic [W-1:0] wq[$];

    bitop_accum_if #(.WIDTH(W), .CNT_W(CW)) bus ();
    bitop_accum #(.WIDTH(W), .CNT_W(CW)) dut (.clk(clk), .reset(reset), .bus(bus.slave));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [W-1:0] ref_data(input logic [1:0] m);
        logic [W-1:0] r;
        r = wq[0];
        for (int i = 1; i < wq.size(); i++)
            case (m)
                2'b01:   r = r & wq[i];
                2'b10:   r = r ^ wq[i];
                default: r = r | wq[i];
            endcase
        return m == 2'b11 ? ~r : r;
    endfunction

    function automatic int ref_count();
        return wq.size() > SAT ? SAT : wq.size();
    endfunction

    task automatic drive_frame(input logic [1:0] m, input bit gaps);
        for (int i = 0; i < wq.size(); i++) begin
            if (gaps) repeat ($urandom_range(0, 2)) begin
                bus.in_valid = 0;
                bus.in_data  = W'($urandom);
                @(posedge clk); #1;
            end
            bus.in_valid = 1;
            bus.in_data  = wq[i];
            bus.in_last  = i == wq.size() - 1;
            bus.in_mode  = i == 0 ? m : 2'($urandom);
            @(posedge clk); #1;
        end
        bus.in_valid = 0;
        bus.in_last  = 0;
    endtask

    task automatic pop_result();
        bus.out_ready = 1;
        @(posedge clk); #1;
        bus.out_ready = 0;
    endtask

    task automatic test_reset();
        reset = 1;
        repeat (2) @(posedge clk);
        #1;
        reset = 0;
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready); end
        total++; if (bus.out_data !== '0) begin bad++; $display("FAIL reset_out_data got=%h exp=0", bus.out_data); end
        total++; if (bus.out_count !== '0) begin bad++; $display("FAIL reset_out_count got=%0d exp=0", bus.out_count); end
`ifdef BITOP_ACCUM_ZERO_EN
        total++; if (bus.out_zero !== 1'b0) begin bad++; $display("FAIL reset_out_zero got=%b exp=0", bus.out_zero); end
`endif
    endtask

    task automatic test_reset_mid_frame();
        int seen = 0;
        for (int i = 0; i < 3; i++) begin
            bus.in_valid = 1;
            bus.in_data  = 16'h1111 << i;
            bus.in_last  = 0;
            bus.in_mode  = 2'b00;
            if (i == 2) reset = 1;
            @(posedge clk); #1;
        end
        reset = 0;
        bus.in_valid = 0;
        total++; if (bus.out_valid !== 1'b0 || bus.out_count !== '0 || bus.out_data !== '0) begin
            bad++; $display("FAIL midreset_state got v=%b d=%h c=%0d exp v=0 d=0 c=0", bus.out_valid, bus.out_data, bus.out_count); end
        wq = '{16'h00F0};
        drive_frame(2'b00, 0);
        total++; if (bus.out_valid !== 1'b1 || bus.out_data !== 16'h00F0 || bus.out_count !== 4'd1) begin
            bad++; $display("FAIL midreset_single got v=%b d=%h c=%0d exp v=1 d=00f0 c=1", bus.out_valid, bus.out_data, bus.out_count); end
        pop_result();
        repeat (3) begin if (bus.out_valid) seen++; @(posedge clk); #1; end
        total++; if (seen != 0) begin bad++; $display("FAIL midreset_extra_result got=%0d exp=0", seen); end
    endtask

    task automatic test_or();
        wq = '{16'h0001, 16'h0100, 16'h8000};
        drive_frame(2'b00, 0);
        total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL or_latency got=%b exp=1", bus.out_valid); end
        total++; if (bus.out_data !== 16'h8101) begin bad++; $display("FAIL or_data got=%h exp=8101", bus.out_data); end
        total++; if (bus.out_count !== 4'd3) begin bad++; $display("FAIL or_count got=%0d exp=3", bus.out_count); end
        pop_result();
        total++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            bad++; $display("FAIL or_release got v=%b r=%b exp v=0 r=1", bus.out_valid, bus.in_ready); end
    endtask

    task automatic test_and_xor_hold();
        int errs = 0;
        wq = '{16'hFF0F, 16'h0FFF};
        drive_frame(2'b01, 0);
        bus.in_valid = 1; bus.in_last = 1; bus.in_mode = 2'b10;
        repeat (5) begin
            bus.in_data = W'($urandom);
            if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.out_data !== 16'h0F0F || bus.out_count !== 4'd2) errs++;
            @(posedge clk); #1;
        end
        bus.in_valid = 0;
        total++; if (errs != 0 || bus.out_data !== 16'h0F0F) begin
            bad++; $display("FAIL and_hold got errs=%0d d=%h exp errs=0 d=0f0f", errs, bus.out_data); end
        pop_result();
        wq = '{16'hAAAA, 16'hAAAA, 16'h5555};
        drive_frame(2'b10, 0);
        total++; if (bus.out_data !== 16'h5555 || bus.out_count !== 4'd3) begin
            bad++; $display("FAIL xor_data got d=%h c=%0d exp d=5555 c=3", bus.out_data, bus.out_count); end
        pop_result();
    endtask

    task automatic test_nor_mode_change();
        bus.in_valid = 1; bus.in_data = 16'h0003; bus.in_last = 0; bus.in_mode = 2'b11;
        @(posedge clk); #1;
        bus.in_data = 16'h0004; bus.in_last = 1; bus.in_mode = 2'b00;
        @(posedge clk); #1;
        bus.in_valid = 0; bus.in_last = 0;
        total++; if (bus.out_data !== 16'hFFF8 || bus.out_count !== 4'd2) begin
            bad++; $display("FAIL nor_mode got d=%h c=%0d exp d=fff8 c=2", bus.out_data, bus.out_count); end
        pop_result();
    endtask

    task automatic test_saturation();
        wq = {};
        repeat (19) wq.push_back(16'h0000);
        wq.push_back(16'h0010);
        drive_frame(2'b00, 0);
        total++; if (bus.out_count !== 4'd15 || bus.out_data !== 16'h0010) begin
            bad++; $display("FAIL saturation got d=%h c=%0d exp d=0010 c=15", bus.out_data, bus.out_count); end
        pop_result();
    endtask

    task automatic test_zero();
        wq = '{16'hF0F0, 16'h0F0F};
        drive_frame(2'b01, 0);
        total++; if (bus.out_data !== 16'h0000) begin bad++; $display("FAIL zero_and_data got=%h exp=0000", bus.out_data); end
`ifdef BITOP_ACCUM_ZERO_EN
        total++; if (bus.out_zero !== 1'b1) begin bad++; $display("FAIL zero_flag_set got=%b exp=1", bus.out_zero); end
`endif
        pop_result();
        drive_frame(2'b00, 0);
        total++; if (bus.out_data !== 16'hFFFF) begin bad++; $display("FAIL zero_or_data got=%h exp=ffff", bus.out_data); end
`ifdef BITOP_ACCUM_ZERO_EN
        total++; if (bus.out_zero !== 1'b0) begin bad++; $display("FAIL zero_flag_clear got=%b exp=0", bus.out_zero); end
`endif
        pop_result();
    endtask

    task automatic test_back_to_back();
        int start, expect_cyc, errs;
        logic [1:0] m;
        errs = 0; expect_cyc = 0;
        bus.out_ready = 1;
        start = cyc;
        repeat (4) begin
            m = 2'($urandom);
            wq = {};
            repeat ($urandom_range(1, 5)) wq.push_back(W'($urandom));
            expect_cyc += wq.size() + 1;
            drive_frame(m, 0);
            if (bus.out_valid !== 1'b1 || bus.out_data !== ref_data(m) || bus.out_count !== CW'(ref_count())) errs++;
            @(posedge clk); #1;
            if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) errs++;
        end
        bus.out_ready = 0;
        total++; if (errs != 0) begin bad++; $display("FAIL b2b_results got errs=%0d exp=0", errs); end
        total++; if (cyc - start != expect_cyc) begin bad++; $display("FAIL b2b_period got=%0d exp=%0d", cyc - start, expect_cyc); end
    endtask

    task automatic test_random();
        logic [1:0] m;
        logic [W-1:0] ed;
        for (int f = 0; f < 25; f++) begin
            m = 2'($urandom);
            wq = {};
            repeat ($urandom_range(1, 20)) wq.push_back($urandom_range(0, 3) == 0 ? W'('1) : W'($urandom));
            ed = ref_data(m);
            drive_frame(m, 1);
            repeat ($urandom_range(0, 3)) begin
                total++; if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.out_data !== ed) begin
                    bad++; $display("FAIL rand_hold f=%0d got v=%b r=%b d=%h exp v=1 r=0 d=%h", f, bus.out_valid, bus.in_ready, bus.out_data, ed); end
                @(posedge clk); #1;
            end
            total++; if (bus.out_data !== ed || bus.out_count !== CW'(ref_count())) begin
                bad++; $display("FAIL rand_result f=%0d m=%0d got d=%h c=%0d exp d=%h c=%0d", f, m, bus.out_data, bus.out_count, ed, ref_count()); end
`ifdef BITOP_ACCUM_ZERO_EN
            total++; if (bus.out_zero !== (ed == '0)) begin bad++; $display("FAIL rand_zero f=%0d got=%b exp=%b", f, bus.out_zero, ed == '0); end
`endif
            pop_result();
        end
    endtask

    initial begin
        bus.in_valid = 0; bus.in_data = '0; bus.in_last = 0; bus.in_mode = 2'b00; bus.out_ready = 0;
        test_reset();
        test_reset_mid_frame();
        test_or();
        test_and_xor_hold();
        test_nor_mode_change();
        test_saturation();
        test_zero();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/bitop_accum.md
# bitop_accum

Parametrised, sequential successor to the fixed 16-bit bitwise gate blocks: it applies a selectable bitwise operation (OR, AND, XOR, NOR) cumulatively across a framed stream of WIDTH-bit words and delivers one result word per frame. Input and output both use valid/ready handshakes. The block sits between a word source (for example, a register-file read port or a memory scan) and consumers that need frame-wide reductions such as "any bit set across N words" or a parity mask.

## Interface
Parameters:
- WIDTH, 16, data word width in bits (≥1).
- CNT_W, 4, width of the frame word counter; the counter saturates at 2^CNT_W−1.

Ports:
- clk  input  1  sole clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  in_data, in_last and in_mode are presented.
- in_ready  output  1  block can accept a word this cycle.
- in_data  input  WIDTH  operand word.
- in_last  input  1  marks the final word of the frame.
- in_mode  input  2  op select: 00 OR, 01 AND, 10 XOR, 11 NOR; sampled only on a frame's first word.
- out_valid  output  1  result held and valid.
- out_ready  input  1  consumer accepts the result.
- out_data  output  WIDTH  frame result.
- out_count  output  CNT_W  number of words in the frame, saturating.
- out_zero  output  1  present only with BITOP_ACCUM_ZERO_EN; high when out_data is all zeros.

## Operation
- A word transfers when in_valid && in_ready. A result transfers when out_valid && out_ready.
- The state machine has three states: IDLE, ACCUM and HOLD.
- **IDLE**: in_ready=1.
  - On transfer: acc←in_data, mode_r←in_mode, cnt←1.
  - If in_last, go to HOLD; otherwise go to ACCUM.
- **ACCUM**: in_ready=1.
  - On transfer: acc←acc OP in_data, where OP is OR/AND/XOR per mode_r. Mode 11 accumulates as OR.
  - cnt←cnt+1, saturating at all-ones.
  - If in_last, go to HOLD.
  - in_mode is ignored in this state.
- **HOLD**: in_ready=0, out_valid=1.
  - out_data = acc, except for mode 11, where out_data = ~acc.
  - out_count = cnt.
  - On result transfer, go to IDLE.
- out_data and out_count are registered and stable throughout HOLD, even if out_ready is held low indefinitely.
- Frames of a single word are legal: out_data = in_data, inverted for NOR, and out_count = 1.
- Width rules:
  - All operations are bitwise over WIDTH bits; there is no carry.
  - cnt never wraps. Once it reaches 2^CNT_W−1 it stays there while the frame continues to be accumulated correctly.
- In IDLE and ACCUM, out_valid=0. out_data and out_count hold their last values and must not be interpreted.
- Reset:
  - state←IDLE, acc←0, cnt←0, mode_r←00.
  - Outputs: out_valid=0, out_data=0, out_count=0, in_ready=1 from the first cycle after reset.
  - A reset during ACCUM or HOLD discards the partial frame or the pending result; nothing is emitted for it.

## Timing
- Result latency: out_valid rises on the clock edge that accepts the in_last word, so the result is visible the next cycle.
- in_ready is driven by state only and has no combinational path from out_ready.
  - Consequence: there is one bubble per frame.
  - The minimum period for a frame of N words is N+1 cycles when out_ready is tied high.
- The next frame's first word can be accepted the cycle after the result transfer.
- in_valid deasserted mid-frame stalls ACCUM indefinitely; acc and cnt are held.
- If reset is asserted in the same cycle as a transfer, reset wins and the word is dropped.

## Configuration
- The macro is BITOP_ACCUM_ZERO_EN.
- **Defined**: the out_zero port exists.
  - It is registered alongside out_data and equals (out_data == 0), so it is the inverse of the bitwise OR-reduction of the result.
  - Reset value is 0.
- **Undefined**: the port and its logic are absent. All other behaviour is identical.

## Test plan
- **Reset mid-frame, then single-word frame**:
  - Stimulus: with WIDTH=16, send 2 words of a 4-word OR frame, assert reset for 1 cycle, then send the single-word frame 0x00F0/last in mode OR.
  - Required: exactly one result, out_data=0x00F0, out_count=1.
- **OR frame**:
  - Stimulus: mode 00, words 0x0001, 0x0100, 0x8000 with last on the third word.
  - Required: out_data=0x8101, out_count=3, out_valid asserted the cycle after the last word.
- **AND and XOR with a held output**:
  - Stimulus: AND frame 0xFF0F, 0x0FFF, then XOR frame 0xAAAA, 0xAAAA, 0x5555. Hold out_ready=0 for 5 cycles on the first result.
  - Required: first result 0x0F0F held stable with in_ready=0 throughout the stall; second result 0x5555.
- **NOR and mid-frame mode change**:
  - Stimulus: in_mode=11 on the first word 0x0003, then in_mode=00 on the second word 0x0004/last.
  - Required: out_data=0xFFF8, because mode_r stays NOR.
- **Count saturation**:
  - Stimulus: with CNT_W=4, an OR frame of 20 words of 0x0000 with word 20 = 0x0010/last.
  - Required: out_count=15, out_data=0x0010.
- **Zero flag** (BITOP_ACCUM_ZERO_EN defined):
  - Stimulus: AND frame 0xF0F0, 0x0F0F.
  - Required: out_data=0x0000 with out_zero=1. An OR frame of the same words gives out_zero=0.
